cordic_phase_sampler: RTL

- Downstream consumer of the 1 MHz CORDIC timing pulse (200-cycle high / 200-cycle low gate).
- On each rising edge of the gate, arms and captures the next valid I/Q sample.
- Runs an iterative vectoring CORDIC, one iteration per clock, and emits phase and magnitude with a one-cycle valid strobe.
- Feeds the phase-2 frequency-tracking loop.

---
 rtl/cordic_pkg.sv | 30 +++
 rtl/cordic_phase_sampler_if.sv | 26 ++
 rtl/cordic_vec_step.sv | 40 ++++
 rtl/cordic_phase_sampler.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the vectoring CORDIC phase sampler.
// Holds the arctangent table, the 1/K gain constant and the FSM state encoding.
package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_PREROT,
      ST_ITER,
      ST_DONE
   } state_t;

   localparam int KINV_Q15 = 19898;

   // round(atan(2^-k) / (2*pi) * 2^16), k = 0..15
   localparam logic [15:0] ATAN_TABLE [16] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297,
      16'd651,  16'd326,  16'd163,  16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,
      16'd3,    16'd1,    16'd1,    16'd0
   };

   function automatic logic [31:0] atan_entry(input int k, input int pw);
      logic [31:0] base;
      base = 32'(ATAN_TABLE[k]);
      if (pw >= 16) return base << (pw - 16);
      else          return base >> (16 - pw);
   endfunction

endpackage

// File: rtl/cordic_phase_sampler_if.sv
// Sample/result bundle between the timing gate, the I/Q source and the phase sampler.
interface cordic_phase_sampler_if #(
   parameter int DW = 16,
   parameter int PW = 16
);
   logic                 gate;
   logic                 in_valid;
   logic signed [DW-1:0] i_in;
   logic signed [DW-1:0] q_in;
   logic [PW-1:0]        phase_out;
   logic [DW+1:0]        mag_out;
   logic                 out_valid;
   logic                 busy;
   logic                 overrun;
   logic                 miss;

   modport master (
      output gate, in_valid, i_in, q_in,
      input  phase_out, mag_out, out_valid, busy, overrun, miss
   );

   modport slave (
      input  gate, in_valid, i_in, q_in,
      output phase_out, mag_out, out_valid, busy, overrun, miss
   );
endinterface

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation; the top reuses a single instance for every step k.
module cordic_vec_step
   import cordic_pkg::*;
#(
   parameter int XW = 18,
   parameter int PW = 16
) (
   input  logic signed [XW-1:0] x,
   input  logic signed [XW-1:0] y,
   input  logic [PW-1:0]        z,
   input  logic [3:0]           k,
   output logic signed [XW-1:0] x_next,
   output logic signed [XW-1:0] y_next,
   output logic [PW-1:0]        z_next
);

   logic signed [XW-1:0] x_sh;
   logic signed [XW-1:0] y_sh;
   logic [PW-1:0]        ang;

   always_comb begin
      // NOTE: every output gets a value on every path so no latch is inferred.
      x_sh   = x >>> k;
      y_sh   = y >>> k;
      ang    = PW'(atan_entry(int'(k), PW));
      x_next = x;
      y_next = y;
      z_next = z;
      if (!y[XW-1]) begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + ang;
      end else begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - ang;
      end
   end

endmodule

// File: rtl/cordic_phase_sampler.sv
// Gate-triggered I/Q capture followed by an iterative vectoring CORDIC (phase + magnitude).
// Optional macro CORDIC_GAIN_COMP_EN scales mag_out by 1/K at the cost of one extra cycle.
module cordic_phase_sampler
   import cordic_pkg::*;
#(
   parameter int DW   = 16,
   parameter int PW   = 16,
   parameter int ITER = 12
) (
   input logic                    clk,
   input logic                    rst,
   cordic_phase_sampler_if.slave  bus
);

   localparam int XW = DW + 2;

   state_t               state;
   logic                 gate_q;
   logic                 rise;
   logic signed [XW-1:0] x_r;
   logic signed [XW-1:0] y_r;
   logic [PW-1:0]        z_r;
   logic [3:0]           k_r;
   logic signed [XW-1:0] x_nx;
   logic signed [XW-1:0] y_nx;
   logic [PW-1:0]        z_nx;
   logic                 busy_r;
   logic                 overrun_r;
   logic                 miss_r;
   logic                 fin_vld;
   logic signed [XW-1:0] fin_x;
   logic [PW-1:0]        fin_z;

   assign rise = bus.gate & ~gate_q;

   cordic_vec_step #(.XW(XW), .PW(PW)) u_step (
      .x      (x_r),
      .y      (y_r),
      .z      (z_r),
      .k      (k_r),
      .x_next (x_nx),
      .y_next (y_nx),
      .z_next (z_nx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         gate_q    <= 1'b0;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         k_r       <= '0;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
         miss_r    <= 1'b0;
         fin_vld   <= 1'b0;
         fin_x     <= '0;
         fin_z     <= '0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees pre-edge state.
         gate_q    <= bus.gate;
         overrun_r <= 1'b0;
         miss_r    <= 1'b0;
         fin_vld   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  state  <= ST_ARM;
                  busy_r <= 1'b1;
               end
            end
            ST_ARM: begin
               if (bus.in_valid) begin
                  x_r   <= {{2{bus.i_in[DW-1]}}, bus.i_in};
                  y_r   <= {{2{bus.q_in[DW-1]}}, bus.q_in};
                  state <= ST_PREROT;
               end else if (!bus.gate) begin
                  miss_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            ST_PREROT: begin
               // Fold the left half-plane onto the right so the micro-rotations converge.
               if (x_r[XW-1]) begin
                  x_r <= -x_r;
                  y_r <= -y_r;
                  z_r <= {1'b1, {(PW-1){1'b0}}};
               end else begin
                  z_r <= '0;
               end
               k_r   <= '0;
               state <= ST_ITER;
            end
            ST_ITER: begin
               x_r <= x_nx;
               y_r <= y_nx;
               z_r <= z_nx;
               k_r <= k_r + 4'd1;
               if (k_r == 4'(ITER - 1)) state <= ST_DONE;
            end
            ST_DONE: begin
               fin_vld <= 1'b1;
               fin_x   <= x_r;
               fin_z   <= z_r;
               busy_r  <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
         if (rise && (state == ST_PREROT || state == ST_ITER || state == ST_DONE))
            overrun_r <= 1'b1;
      end
   end

   assign bus.busy    = busy_r;
   assign bus.overrun = overrun_r;
   assign bus.miss    = miss_r;

`ifdef CORDIC_GAIN_COMP_EN
   logic [XW+14:0] prod;
   logic [XW-1:0]  mag_r;
   logic [PW-1:0]  phase_r;
   logic           vld_r;

   assign prod = (XW+15)'($unsigned(fin_x)) * (XW+15)'(KINV_Q15);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mag_r   <= '0;
         phase_r <= '0;
         vld_r   <= 1'b0;
      end else begin
         vld_r <= fin_vld;
         if (fin_vld) begin
            mag_r   <= XW'(prod >> 15);
            phase_r <= fin_z;
         end
      end
   end

   assign bus.out_valid = vld_r;
   assign bus.mag_out   = mag_r;
   assign bus.phase_out = phase_r;
`else
   assign bus.out_valid = fin_vld;
   assign bus.mag_out   = $unsigned(fin_x);
   assign bus.phase_out = fin_z;
`endif

endmodule
